debounce_edge_detect: RTL and testbench

- Conditions one raw asynchronous level input, e.g. a mechanical push-button.
- Processing chain: synchroniser, then counter-based debouncer, then edge detector.
- Outputs a clean debounced level plus single-cycle rise, fall and any-edge pulses.
- Sits between board I/O pins and the control logic that consumes button events.

---
 rtl/debounce_edge_detect_if.sv | 49 ++++
 rtl/debounce_edge_detect.sv | 86 ++++++++
 tb/tb_debounce_edge_detect.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/debounce_edge_detect_if.sv
// Signal bundle between the button conditioner (master) and its consumer (slave).
// Optional ready/valid press handshake is present when DEBOUNCE_HANDSHAKE_EN is defined.
interface debounce_edge_detect_if;
    logic bit_in;
    logic bit_out;
    logic pos_edge;
    logic neg_edge;
    logic any_edge;
`ifdef DEBOUNCE_HANDSHAKE_EN
    logic ready;
    logic valid;

    modport master (
        input  bit_in,
        input  ready,
        output bit_out,
        output pos_edge,
        output neg_edge,
        output any_edge,
        output valid
    );

    modport slave (
        output bit_in,
        output ready,
        input  bit_out,
        input  pos_edge,
        input  neg_edge,
        input  any_edge,
        input  valid
    );
`else
    modport master (
        input  bit_in,
        output bit_out,
        output pos_edge,
        output neg_edge,
        output any_edge
    );

    modport slave (
        output bit_in,
        input  bit_out,
        input  pos_edge,
        input  neg_edge,
        input  any_edge
    );
`endif
endinterface

// File: rtl/debounce_edge_detect.sv
// Synchroniser -> counter debouncer -> edge detector for one raw button level.
// Define DEBOUNCE_HANDSHAKE_EN to add a ready/valid latch for press (falling) events.
module debounce_edge_detect #(
    parameter int unsigned CYCLES      = 255,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_LEVEL = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    debounce_edge_detect_if.master bus
);

    localparam int unsigned      CNT_W    = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   prev_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.bit_in};
    assign sync   = sync_q[SYNC_STAGES-1];

    // Any cycle where sync agrees with the output restarts the count, so glitches never accumulate.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            prev_q  <= RESET_LEVEL;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    // prev is loaded with the same level as bit_out at reset, so release produces no edge.
    assign bus.bit_out  = level_q;
    assign bus.pos_edge = level_q & ~prev_q;
    assign bus.neg_edge = ~level_q & prev_q;
    assign bus.any_edge = level_q ^ prev_q;

`ifdef DEBOUNCE_HANDSHAKE_EN
    logic valid_q;
    logic valid_d;

    // A new press takes priority over a same-cycle acknowledge.
    always_comb begin
        valid_d = valid_q;
        if (bus.neg_edge) begin
            valid_d = 1'b1;
        end else if (bus.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign bus.valid = valid_q;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect with CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=1.
module tb_debounce_edge_detect;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    debounce_edge_detect_if dif ();

    debounce_edge_detect #(
        .CYCLES      (4),
        .SYNC_STAGES (2),
        .RESET_LEVEL (1'b1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bit_in was just changed; the output must move on edge n and pulse for that one cycle only.
    task automatic expect_transition(input string tag, input int n, input logic from_v, input logic to_v);
        for (int i = 1; i < n; i++) begin
            tick();
            check({tag, "_hold"}, 32'(dif.bit_out), 32'(from_v));
            check({tag, "_quiet"}, 32'(dif.any_edge), 32'd0);
        end
        tick();
        check({tag, "_level"}, 32'(dif.bit_out), 32'(to_v));
        check({tag, "_pos"}, 32'(dif.pos_edge), 32'(to_v & ~from_v));
        check({tag, "_neg"}, 32'(dif.neg_edge), 32'(~to_v & from_v));
        check({tag, "_any"}, 32'(dif.any_edge), 32'd1);
        tick();
        check({tag, "_after_level"}, 32'(dif.bit_out), 32'(to_v));
        check({tag, "_after_any"}, 32'(dif.any_edge), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        dif.bit_in = 1'b0;
`ifdef DEBOUNCE_HANDSHAKE_EN
        dif.ready  = 1'b1;
`endif

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_level", 32'(dif.bit_out), 32'd1);
            check("rst_pos", 32'(dif.pos_edge), 32'd0);
            check("rst_neg", 32'(dif.neg_edge), 32'd0);
            check("rst_any", 32'(dif.any_edge), 32'd0);
`ifdef DEBOUNCE_HANDSHAKE_EN
            check("rst_valid", 32'(dif.valid), 32'd0);
`endif
        end
        reset = 1'b0;
        expect_transition("rst_release", 6, 1'b1, 1'b0);

        dif.bit_in = 1'b1;
        expect_transition("release1", 6, 1'b0, 1'b1);

`ifdef DEBOUNCE_HANDSHAKE_EN
        check("hs_idle_valid", 32'(dif.valid), 32'd0);
        dif.ready = 1'b0;
`endif
        dif.bit_in = 1'b0;
        expect_transition("press", 6, 1'b1, 1'b0);
`ifdef DEBOUNCE_HANDSHAKE_EN
        check("hs_set_valid", 32'(dif.valid), 32'd1);
        tick();
        check("hs_hold_valid", 32'(dif.valid), 32'd1);
        dif.ready = 1'b1;
        tick();
        check("hs_ack_valid", 32'(dif.valid), 32'd0);
        dif.ready = 1'b0;
`endif

        dif.bit_in = 1'b1;
        expect_transition("release2", 6, 1'b0, 1'b1);

        // Bounce: 0 for three clocks, a one-clock 1 glitch, then 0 held.
        dif.bit_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bounce_pre", 32'(dif.bit_out), 32'd1);
        end
        dif.bit_in = 1'b1;
        tick();
        check("bounce_glitch", 32'(dif.bit_out), 32'd1);
        dif.bit_in = 1'b0;
        expect_transition("bounce", 6, 1'b1, 1'b0);

        dif.bit_in = 1'b1;
        expect_transition("release3", 6, 1'b0, 1'b1);

        // Reset in the middle of a count must discard it.
        dif.bit_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_pre", 32'(dif.bit_out), 32'd1);
        end
        reset = 1'b1;
        tick();
        check("midrst_level", 32'(dif.bit_out), 32'd1);
        check("midrst_any", 32'(dif.any_edge), 32'd0);
        reset = 1'b0;
        expect_transition("midrst", 6, 1'b1, 1'b0);

`ifdef DEBOUNCE_HANDSHAKE_EN
        dif.ready  = 1'b1;
        dif.bit_in = 1'b1;
        expect_transition("release4", 6, 1'b0, 1'b1);
        check("hs_pre_valid", 32'(dif.valid), 32'd0);
        dif.bit_in = 1'b0;
        expect_transition("press2", 6, 1'b1, 1'b0);
        check("hs_setwins_valid", 32'(dif.valid), 32'd1);
        tick();
        check("hs_setwins_clear", 32'(dif.valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
